// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_responder
//  Description : Unified instruction/data RAM behind the multicycle CPU memory
//                port, with a boot-loader FSM that streams a program image in
//                over a valid/ready port and holds the CPU in reset meanwhile.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  mem_wr_en,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  cpu_rst_n,
    output logic                  load_done,
    output logic                  mem_err,
    output logic                  ld_overflow
);

    localparam int c_IDX_W = $clog2(MEM_DEPTH);
    // One extra bit so the pointer can represent MEM_DEPTH itself.
    localparam int c_PTR_W = c_IDX_W + 1;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [c_PTR_W-1:0]      r_ld_ptr;
    logic                    r_mem_err;
    logic                    r_ld_overflow;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic                    w_ld_ready_st;
    logic                    w_run;
    logic                    w_hs;
    logic                    w_start;
    logic                    w_ptr_full;
    logic                    w_in_range;
    logic                    w_misaligned;
    logic [c_IDX_W-1:0]      w_idx;
    logic                    w_cpu_wr;

    // CPU address decode: any bit above the RAM index makes the access out of range.
    assign w_idx        = mem_addr[c_IDX_W+1:2];
    assign w_in_range   = (mem_addr[ADDR_WIDTH-1:c_IDX_W+2] == '0);
    assign w_misaligned = |mem_addr[1:0];

    assign w_run      = (r_state == S_RUN);
    // ld_ready is forced low while reset is held so no word can be accepted then.
    assign ld_ready   = w_ld_ready_st & ~sys_rst;
    assign w_hs       = ld_valid & ld_ready;
    assign w_start    = ld_start & w_run;
    assign w_ptr_full = r_ld_ptr[c_IDX_W];
    assign w_cpu_wr   = w_run & mem_wr_en & w_in_range;

    assign mem_data_out = w_in_range ? r_mem[w_idx] : '0;
    assign mem_err      = r_mem_err;
    assign ld_overflow  = r_ld_overflow;

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= S_LOAD;
        else         r_state <= w_next_state;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next_state  = r_state;
        w_ld_ready_st = 1'b0;
        cpu_rst_n     = 1'b0;
        load_done     = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_ld_ready_st = 1'b1;
                if (w_hs && ld_last) w_next_state = S_RELEASE;
            end
            S_RELEASE: begin
                w_next_state = S_RUN;
            end
            S_RUN: begin
                cpu_rst_n = 1'b1;
                load_done = 1'b1;
                if (ld_start) w_next_state = S_LOAD;
            end
            default: begin
                w_next_state = S_LOAD;
            end
        endcase
    end

    // Load pointer, overflow flag and registered illegal-access pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ld_ptr      <= '0;
            r_ld_overflow <= 1'b0;
            r_mem_err     <= 1'b0;
        end else begin
            r_mem_err <= w_run & (~w_in_range | w_misaligned);
            if (w_start) begin
                r_ld_ptr      <= '0;
                r_ld_overflow <= 1'b0;
            end else if (w_hs) begin
                // Saturates at MEM_DEPTH so the pointer never wraps back into RAM.
                if (!w_ptr_full) r_ld_ptr      <= r_ld_ptr + c_PTR_W'(1);
                else             r_ld_overflow <= 1'b1;
            end
        end
    end

    // RAM write port; loader and CPU writes are mutually exclusive by state.
    always_ff @(posedge sys_clk) begin
        if (w_hs && !w_ptr_full) r_mem[r_ld_ptr[c_IDX_W-1:0]] <= ld_data;
        else if (w_cpu_wr)       r_mem[w_idx]                  <= mem_data_in;
    end

endmodule
`default_nettype wire
